// File: rtl/axis_bram_adapter_pkg.sv
// Shared types and helpers for the AXI4-Stream store-and-forward BRAM frame buffer.
package axis_bram_adapter_pkg;

  typedef enum logic [1:0] {
    StFill,
    StRdAddr,
    StRdWait,
    StOut
  } state_e;

  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/axis_bram_adapter.sv
// Store-and-forward AXI4-Stream frame buffer on an external single-port BRAM.
// Optional frame statistics outputs are enabled with AXIS_BRAM_FRAME_STATS_EN.
module axis_bram_adapter
  import axis_bram_adapter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                                aclk,
  input  logic                                areset,
  output logic                                bram_clk,
  output logic                                bram_en,
  output logic [strb_width(DATA_WIDTH)-1:0]   bram_wen,
  output logic [ADDR_WIDTH-1:0]               bram_addr,
  output logic [DATA_WIDTH-1:0]               bram_din,
  input  logic [DATA_WIDTH-1:0]               bram_dout,
  output logic                                s_axis_tready,
  input  logic [DATA_WIDTH-1:0]               s_axis_tdata,
  input  logic [strb_width(DATA_WIDTH)-1:0]   s_axis_tstrb,
  input  logic                                s_axis_tlast,
  input  logic                                s_axis_tvalid,
  output logic                                m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]               m_axis_tdata,
  output logic [strb_width(DATA_WIDTH)-1:0]   m_axis_tstrb,
  output logic                                m_axis_tlast,
  input  logic                                m_axis_tready
`ifdef AXIS_BRAM_FRAME_STATS_EN
  ,
  output logic [ADDR_WIDTH:0]                 frame_len,
  output logic                                frame_done
`endif
);

  localparam int unsigned StrbWidth = strb_width(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0] LenOne = (ADDR_WIDTH + 1)'(1);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic                  s_ready_q;
  logic                  m_valid_q;
  logic                  m_last_q;
  logic [DATA_WIDTH-1:0] m_data_q;

  logic in_hs;
  logic out_hs;
  logic frame_close;
  logic rd_last;

  assign in_hs       = (state_q == StFill) & s_ready_q & s_axis_tvalid;
  // A full buffer closes the frame even without tlast.
  assign frame_close = in_hs & (s_axis_tlast | (wr_ptr_q == {ADDR_WIDTH{1'b1}}));
  assign out_hs      = (state_q == StOut) & m_valid_q & m_axis_tready;
  assign rd_last     = ({1'b0, rd_ptr_q} == (len_q - LenOne));

  assign bram_clk      = aclk;
  assign bram_din      = s_axis_tdata;
  assign s_axis_tready = s_ready_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tstrb  = {StrbWidth{1'b1}};

  always_comb begin
    bram_en   = 1'b0;
    bram_wen  = '0;
    bram_addr = rd_ptr_q;
    unique case (state_q)
      StFill: begin
        bram_en   = in_hs;
        bram_wen  = in_hs ? s_axis_tstrb : '0;
        bram_addr = wr_ptr_q;
      end
      StRdAddr: bram_en = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= StFill;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      len_q     <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else begin
      unique case (state_q)
        StFill: begin
          s_ready_q <= 1'b1;
          if (in_hs) wr_ptr_q <= wr_ptr_q + AddrOne;
          if (frame_close) begin
            len_q     <= {1'b0, wr_ptr_q} + LenOne;
            rd_ptr_q  <= '0;
            s_ready_q <= 1'b0;
            state_q   <= StRdAddr;
          end
        end
        StRdAddr: state_q <= StRdWait;
        StRdWait: begin
          // BRAM read data arrives one cycle after the address.
          m_data_q  <= bram_dout;
          m_valid_q <= 1'b1;
          m_last_q  <= rd_last;
          state_q   <= StOut;
        end
        StOut: begin
          if (out_hs) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            if (m_last_q) begin
              wr_ptr_q  <= '0;
              s_ready_q <= 1'b1;
              state_q   <= StFill;
            end else begin
              rd_ptr_q <= rd_ptr_q + AddrOne;
              state_q  <= StRdAddr;
            end
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

`ifdef AXIS_BRAM_FRAME_STATS_EN
  logic [ADDR_WIDTH:0] frame_len_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      frame_len_q <= '0;
    end else if (frame_close) begin
      frame_len_q <= {1'b0, wr_ptr_q} + LenOne;
    end
  end

  assign frame_len  = frame_len_q;
  assign frame_done = out_hs & m_last_q;
`endif

endmodule

// File: tb/tb_axis_bram_adapter.sv
// Directed self-checking bench for axis_bram_adapter with a behavioural byte-write BRAM.
module tb_axis_bram_adapter;

  logic        aclk = 1'b0;
  logic        areset;
  logic        bram_clk;
  logic        bram_en;
  logic [3:0]  bram_wen;
  logic [9:0]  bram_addr;
  logic [31:0] bram_din;
  logic [31:0] bram_dout;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tstrb;
  logic        s_axis_tlast;
  logic        s_axis_tvalid;
  logic        m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tstrb;
  logic        m_axis_tlast;
  logic        m_axis_tready;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [1024];

  always #5 aclk = ~aclk;

  axis_bram_adapter #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(10)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .bram_clk      (bram_clk),
    .bram_en       (bram_en),
    .bram_wen      (bram_wen),
    .bram_addr     (bram_addr),
    .bram_din      (bram_din),
    .bram_dout     (bram_dout),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
  );

  // Read-first single-port BRAM with byte write enables.
  always @(posedge bram_clk) begin
    if (bram_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bram_wen[b]) mem[bram_addr][8*b +: 8] <= bram_din[8*b +: 8];
      end
      bram_dout <= mem[bram_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] data, input logic [3:0] strb, input logic last,
                           input logic [9:0] addr);
    s_axis_tdata  = data;
    s_axis_tstrb  = strb;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    #1;
    check_eq("in_ready", s_axis_tready, 1'b1);
    check_eq("wr_en", bram_en, 1'b1);
    check_eq("wr_wen", bram_wen, strb);
    check_eq("wr_addr", bram_addr, addr);
    check_eq("wr_din", bram_din, data);
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Expects words base+k; stalls two cycles on word `stall`, stops before handshaking `stop`.
  task automatic drain(input logic [31:0] base, input int n, input int stall, input int stop);
    int cnt;
    for (int k = 0; k < n; k++) begin
      cnt = 0;
      while (!m_axis_tvalid && cnt < 20) begin
        tick();
        cnt++;
      end
      check_eq("out_lat", cnt, 2);
      check_eq("out_data", m_axis_tdata, base + k);
      check_eq("out_last", m_axis_tlast, (k == n - 1));
      check_eq("out_strb", m_axis_tstrb, 4'hF);
      check_eq("in_ready_drain", s_axis_tready, 1'b0);
      if (k == stop) begin
        m_axis_tready = 1'b0;
        break;
      end
      if (k == stall) begin
        m_axis_tready = 1'b0;
        repeat (2) begin
          tick();
          check_eq("stall_valid", m_axis_tvalid, 1'b1);
          check_eq("stall_data", m_axis_tdata, base + k);
          check_eq("stall_in_ready", s_axis_tready, 1'b0);
        end
        m_axis_tready = 1'b1;
      end
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    areset        = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tstrb  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) tick();
    check_eq("rst_in_ready", s_axis_tready, 1'b0);
    check_eq("rst_valid", m_axis_tvalid, 1'b0);
    check_eq("rst_data", m_axis_tdata, 32'h0);
    check_eq("rst_last", m_axis_tlast, 1'b0);
    check_eq("rst_en", bram_en, 1'b0);
    check_eq("rst_wen", bram_wen, 4'h0);
    areset = 1'b0;
    tick();
    check_eq("post_rst_ready", s_axis_tready, 1'b1);

    // Frame 0..5 with backpressure on word 2.
    for (int i = 0; i < 6; i++) send_beat(32'(i), 4'hF, (i == 5), 10'(i));
    drain(32'd0, 6, 2, 6);

    // Input gap between 7 and 8.
    send_beat(32'd7, 4'hF, 1'b0, 10'd0);
    #1;
    check_eq("gap_en", bram_en, 1'b0);
    check_eq("gap_wen", bram_wen, 4'h0);
    tick();
    send_beat(32'd8, 4'hF, 1'b1, 10'd1);
    drain(32'd7, 2, -1, 2);

    // Partial strobe over mem[0] = 7: only the low two bytes change.
    send_beat(32'hAABBCCDD, 4'b0011, 1'b1, 10'd0);
    drain(32'h0000CCDD, 1, -1, 1);

    // Full buffer closes without tlast.
    for (int i = 0; i < 1024; i++) send_beat(32'(i), 4'hF, 1'b0, 10'(i));
    drain(32'd0, 1024, -1, 1024);

    // Reset while word 3 is presented.
    for (int i = 0; i < 6; i++) send_beat(32'(10 + i), 4'hF, (i == 5), 10'(i));
    drain(32'd10, 6, -1, 3);
    areset = 1'b1;
    tick();
    check_eq("mid_rst_valid", m_axis_tvalid, 1'b0);
    check_eq("mid_rst_in_ready", s_axis_tready, 1'b0);
    check_eq("mid_rst_en", bram_en, 1'b0);
    areset        = 1'b0;
    m_axis_tready = 1'b1;
    tick();
    check_eq("mid_rst_release_ready", s_axis_tready, 1'b1);
    send_beat(32'h55, 4'hF, 1'b1, 10'd0);
    drain(32'h55, 1, -1, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axis_bram_adapter.md
Name: axis_bram_adapter

Overview:
Store-and-forward AXI4-Stream frame buffer built on an external single-port BRAM. Beats accepted on the slave stream are written to sequential BRAM words. When the frame closes (tlast or buffer full), the stored words are read back and replayed on the master stream, with tlast on the final word. The block sits between a stream producer and consumer, and the BRAM macro lives outside it.

Parameters:
DATA_WIDTH, 32, stream and BRAM word width in bits; must be a multiple of 8.
ADDR_WIDTH, 10, BRAM word-address width; depth = 2**ADDR_WIDTH words.

Ports:
aclk  in  1  single clock for the streams and the BRAM.
areset  in  1  synchronous, active-high reset.
bram_clk  out  1  equals aclk.
bram_en  out  1  BRAM enable.
bram_wen  out  DATA_WIDTH/8  byte write enables.
bram_addr  out  ADDR_WIDTH  word address.
bram_din  out  DATA_WIDTH  write data to BRAM.
bram_dout  in  DATA_WIDTH  read data; valid one cycle after the read address is presented.
s_axis_tready  out  1  slave ready.
s_axis_tdata  in  DATA_WIDTH  input data.
s_axis_tstrb  in  DATA_WIDTH/8  input byte strobes.
s_axis_tlast  in  1  end of input frame.
s_axis_tvalid  in  1  input valid.
m_axis_tvalid  out  1  output valid.
m_axis_tdata  out  DATA_WIDTH  output data.
m_axis_tstrb  out  DATA_WIDTH/8  output strobes; always all ones.
m_axis_tlast  out  1  marks the last word of the frame.
m_axis_tready  in  1  output ready.

Behaviour:
- Reset values: state FILL, wr_ptr=0, rd_ptr=0, len=0.
- Reset values of outputs: bram_en=0, bram_wen=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
- Reset values of tready: s_axis_tready=0 while areset is high; it becomes 1 in the first cycle after reset is released.
- Reset has priority over every other event, including mid-frame; BRAM contents are not cleared.
- FILL state:
  - s_axis_tready=1.
  - Each handshake (tvalid&tready) drives bram_en=1, bram_wen=tstrb, bram_addr=wr_ptr and bram_din=tdata combinationally in the same cycle, then increments wr_ptr.
  - When tvalid is low, bram_en=0 and bram_wen=0.
- FILL exit: on a handshake with tlast=1, or on a handshake with wr_ptr=2**ADDR_WIDTH-1 (buffer full), set len=wr_ptr+1, rd_ptr=0, and move to RD_ADDR. s_axis_tready is 0 from the next cycle on.
- RD_ADDR: bram_en=1, bram_wen=0, bram_addr=rd_ptr. Next state RD_WAIT.
- RD_WAIT: capture bram_dout into the output data register. Set m_axis_tvalid=1, and set m_axis_tlast=1 if rd_ptr==len-1. Next state OUT.
- OUT: hold tvalid, tdata and tlast stable until m_axis_tready=1.
- OUT on handshake: clear tvalid and tlast. If this was the last word, reset wr_ptr=0 and return to FILL. Otherwise increment rd_ptr and go to RD_ADDR.
- Throughput: 3 cycles per output word at full ready; first-output latency is 2 cycles after the closing input handshake.
- A zero-length frame cannot occur, since len >= 1 always.
- Pointer wrap: wr_ptr never exceeds depth-1, because a full buffer forces the drain.
- s_axis_tstrb affects only bram_wen. A beat with tstrb=0 still advances wr_ptr and counts toward len.

Optional Feature:
AXIS_BRAM_FRAME_STATS_EN:
- When defined, two extra outputs are added: frame_len (ADDR_WIDTH+1 bits) and frame_done (1 bit).
- frame_len is registered to len when the frame closes and holds until the next frame closes; reset value 0.
- frame_done pulses for 1 cycle on the final output handshake.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- Package axis_bram_adapter_pkg: the state enum (FILL, RD_ADDR, RD_WAIT, OUT) and a localparam function for the strobe width (DATA_WIDTH/8).
- No sub-module: the FSM and datapath are small enough to stay flat. An optional axis_bram_reader sub-module may hold the RD_ADDR/RD_WAIT/OUT path.

Test Plan:
- Frame of data 0,1,2,3,4,5, tvalid continuous, tlast on 5, tstrb=4'hF -> BRAM writes to addresses 0-5 with bram_wen=4'hF. Output is 0..5 in order, m_axis_tlast only on 5, and tstrb=4'hF on every word.
- Output backpressure: m_axis_tready low for 2 cycles while word 2 is presented -> tdata=2 and tvalid held stable, no word lost or duplicated, s_axis_tready stays 0 during the drain.
- Input gaps: tvalid toggles 1,0,1 while sending 7,8 with tlast on 8 -> bram_en is low during the gap, and the output is 7,8 with tlast on 8.
- Full buffer: 1024 beats of value i with no tlast -> drain starts after beat 1023, and m_axis_tlast is asserted on word 1023.
- Strobes: a beat with tstrb=4'b0011 -> bram_wen=4'b0011 for that address. The output strobe remains 4'hF.
- Reset mid-drain: assert areset while word 3 is valid -> next cycle m_axis_tvalid=0 and s_axis_tready=0. After release, s_axis_tready=1 and a new frame is stored from address 0.
